// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a short in-order pipeline. It detects load-use
// hazards between the EX and ID stages, requests EX->ID forwarding for ALU
// results, and sequences the stall, bubble and flush controls for taken
// redirects and for a data memory that is not ready.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   id_valid                   ID stage holds a real instruction
//   id_rs1_addr, id_rs2_addr   ID source register indices
//   id_uses_rs1, id_uses_rs2   ID instruction reads that source
//   ex_valid                   EX stage holds a real instruction
//   ex_rd_addr                 EX destination register
//   ex_wb_en, ex_wb_from_mem   EX writes back / writeback comes from a load
//   ex_redirect                EX resolved a taken jump/branch this cycle
//   mem_busy                   data memory not ready, whole pipe holds
//   stall_front                hold PC and IF/ID
//   stall_id_ex                hold ID/EX
//   bubble_id                  suppress the instruction entering EX
//   flush_if_id                invalidate IF/ID
//   rs1_take_prev1, rs2_take_prev1  forward EX result to the ID operand
//   state                      RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3
//   stall_cnt, flush_cnt       saturating event counters
//
// Control outputs are a combinational decode of the registered state and
// the current inputs so they act in the same cycle the event is seen.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_wb_en,
    input  logic        ex_wb_from_mem,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        stall_front,
    output logic        stall_id_ex,
    output logic        bubble_id,
    output logic        flush_if_id,
    output logic        rs1_take_prev1,
    output logic        rs2_take_prev1,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    state_t      cur_s;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;
    logic        ex_writes_s;
    logic        rs1_match_s;
    logic        rs2_match_s;
    logic        load_use_s;
    logic        fwd1_s;
    logic        fwd2_s;
    logic        flush_evt_s;
    logic        sf_s;
    logic        sie_s;
    logic        bub_s;
    logic        fl_s;

    // Register-match terms; x0 never hazards nor forwards.
    always_comb begin
        ex_writes_s = ex_valid & ex_wb_en & (ex_rd_addr != 5'd0);
        rs1_match_s = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        rs2_match_s = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        load_use_s  = ex_writes_s & ex_wb_from_mem & id_valid & (rs1_match_s | rs2_match_s);
        fwd1_s      = ex_writes_s & ~ex_wb_from_mem & rs1_match_s;
        fwd2_s      = ex_writes_s & ~ex_wb_from_mem & rs2_match_s;
    end

    // While reset is held the outputs decode as if the FSM were in RUN.
    always_comb begin
        if (!rst) begin
            cur_s = ST_RUN;
        end else begin
            cur_s = state_q;
        end
    end

    // Control decode and next-state selection.
    always_comb begin
        sf_s           = 1'b0;
        sie_s          = 1'b0;
        bub_s          = 1'b0;
        fl_s           = 1'b0;
        rs1_take_prev1 = 1'b0;
        rs2_take_prev1 = 1'b0;
        flush_evt_s    = 1'b0;
        state_d        = cur_s;
        case (cur_s)
            ST_RUN: begin
                if (mem_busy) begin
                    sf_s    = 1'b1;
                    sie_s   = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    fl_s        = 1'b1;
                    bub_s       = 1'b1;
                    flush_evt_s = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (load_use_s) begin
                    sf_s    = 1'b1;
                    bub_s   = 1'b1;
                    state_d = ST_LOAD_STALL;
                end else begin
                    // Only reached with no stall/bubble, so forwarding is safe.
                    rs1_take_prev1 = fwd1_s;
                    rs2_take_prev1 = fwd2_s;
                    state_d        = ST_RUN;
                end
            end
            ST_LOAD_STALL: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The second half of the redirect bubble is always issued.
                bub_s = 1'b1;
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    sf_s    = 1'b1;
                    sie_s   = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating counter next values.
    always_comb begin
        if (sf_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // FSM state and event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_front = sf_s;
    assign stall_id_ex = sie_s;
    assign bubble_id   = bub_s;
    assign flush_if_id = fl_s;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_hazard_ctrl: a table of per-cycle input records with
// hand-derived expected outputs, followed by short hand-written sequences for
// the multi-cycle corners (flush into memory wait, reset in MEM_WAIT, the
// three-cycle memory hold, and stall counter saturation).
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ex_valid;
        logic [4:0] rd;
        logic       wb;
        logic       ld;
        logic       redir;
        logic       busy;
    } in_t;

    typedef struct packed {
        logic       sf;
        logic       sie;
        logic       bub;
        logic       fl;
        logic       f1;
        logic       f2;
        logic [1:0] st;
    } out_t;

    typedef struct {
        in_t  vin;
        out_t vout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        ex_valid, ex_wb_en, ex_wb_from_mem, ex_redirect, mem_busy;
    logic        stall_front, stall_id_ex, bubble_id, flush_if_id;
    logic        rs1_take_prev1, rs2_take_prev1;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_rd_addr     (ex_rd_addr),
        .ex_wb_en       (ex_wb_en),
        .ex_wb_from_mem (ex_wb_from_mem),
        .ex_redirect    (ex_redirect),
        .mem_busy       (mem_busy),
        .stall_front    (stall_front),
        .stall_id_ex    (stall_id_ex),
        .bubble_id      (bubble_id),
        .flush_if_id    (flush_if_id),
        .rs1_take_prev1 (rs1_take_prev1),
        .rs2_take_prev1 (rs2_take_prev1),
        .state          (state),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // EX holds an instruction writing rd; ID reads rs1/rs2 as flagged.
    function automatic in_t mk(input logic ld, input logic [4:0] rd,
                               input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2);
        in_t v;
        v          = '0;
        v.id_valid = 1'b1;
        v.ex_valid = 1'b1;
        v.wb       = 1'b1;
        v.ld       = ld;
        v.rd       = rd;
        v.rs1      = r1;
        v.u1       = u1;
        v.rs2      = r2;
        v.u2       = u2;
        return v;
    endfunction

    function automatic out_t mo(input logic sf, input logic sie, input logic bub,
                                input logic fl, input logic f1, input logic f2,
                                input logic [1:0] st);
        out_t o;
        o = {sf, sie, bub, fl, f1, f2, st};
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.vin  = i;
        v.vout = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v, input logic rstv);
        rst            = rstv;
        id_valid       = v.id_valid;
        id_rs1_addr    = v.rs1;
        id_rs2_addr    = v.rs2;
        id_uses_rs1    = v.u1;
        id_uses_rs2    = v.u2;
        ex_valid       = v.ex_valid;
        ex_rd_addr     = v.rd;
        ex_wb_en       = v.wb;
        ex_wb_from_mem = v.ld;
        ex_redirect    = v.redir;
        mem_busy       = v.busy;
    endtask

    // One cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input in_t v, input logic rstv, input out_t e, input string nm);
        out_t act;
        out_t ex;
        @(posedge clk);
        #1;
        drive(v, rstv);
        exp_q.push_back(e);
        @(negedge clk);
        act = {stall_front, stall_id_ex, bubble_id, flush_if_id,
               rs1_take_prev1, rs2_take_prev1, state};
        ex  = exp_q.pop_front();
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got sf/sie/bub/fl/f1/f2/st=%b want %b", nm, act, ex);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, ex);
        end
    endtask

    initial begin
        in_t z;
        in_t v;
        z = '0;

        // Table of per-cycle vectors; each row continues from the previous state.
        add(z,                                  mo(0,0,0,0,0,0,2'd0)); // 0 idle
        add(mk(0, 5'd7, 5'd3, 1, 5'd7, 1),      mo(0,0,0,0,0,1,2'd0)); // 1 fwd rs2 only
        add(mk(0, 5'd7, 5'd7, 1, 5'd7, 1),      mo(0,0,0,0,1,1,2'd0)); // 2 fwd both
        add(mk(0, 5'd0, 5'd0, 1, 5'd0, 1),      mo(0,0,0,0,0,0,2'd0)); // 3 rd=x0
        add(mk(0, 5'd7, 5'd7, 0, 5'd7, 0),      mo(0,0,0,0,0,0,2'd0)); // 4 sources unused
        v = mk(0, 5'd7, 5'd7, 1, 5'd7, 1); v.ex_valid = 1'b0;
        add(v,                                  mo(0,0,0,0,0,0,2'd0)); // 5 EX invalid
        v = mk(0, 5'd7, 5'd7, 1, 5'd7, 1); v.wb = 1'b0;
        add(v,                                  mo(0,0,0,0,0,0,2'd0)); // 6 no writeback
        add(mk(1, 5'd5, 5'd5, 1, 5'd2, 1),      mo(1,0,1,0,0,0,2'd0)); // 7 load-use x5
        add(mk(0, 5'd5, 5'd5, 1, 5'd5, 1),      mo(0,0,0,0,0,0,2'd1)); // 8 LOAD_STALL, fwd masked
        add(z,                                  mo(0,0,0,0,0,0,2'd0)); // 9
        add(mk(1, 5'd0, 5'd0, 1, 5'd0, 1),      mo(0,0,0,0,0,0,2'd0)); // 10 load to x0
        v = mk(1, 5'd9, 5'd9, 1, 5'd9, 1); v.id_valid = 1'b0;
        add(v,                                  mo(0,0,0,0,0,0,2'd0)); // 11 ID invalid
        add(mk(1, 5'd9, 5'd1, 1, 5'd9, 0),      mo(0,0,0,0,0,0,2'd0)); // 12 rs2 unused
        add(mk(1, 5'd9, 5'd1, 1, 5'd9, 1),      mo(1,0,1,0,0,0,2'd0)); // 13 load-use on rs2
        v = z; v.busy = 1'b1;
        add(v,                                  mo(0,0,0,0,0,0,2'd1)); // 14 LOAD_STALL -> MEM_WAIT
        add(z,                                  mo(0,0,0,0,0,0,2'd3)); // 15 MEM_WAIT, busy low
        add(z,                                  mo(0,0,0,0,0,0,2'd0)); // 16
        v = mk(1, 5'd5, 5'd5, 1, 5'd0, 0); v.redir = 1'b1;
        add(v,                                  mo(0,0,1,1,0,0,2'd0)); // 17 redirect beats load-use
        add(v,                                  mo(0,0,1,0,0,0,2'd2)); // 18 FLUSH ignores events
        add(z,                                  mo(0,0,0,0,0,0,2'd0)); // 19
        v = z; v.redir = 1'b1; v.busy = 1'b1;
        add(v,                                  mo(1,1,0,0,0,0,2'd0)); // 20 busy beats redirect
        v = z; v.redir = 1'b1;
        add(v,                                  mo(0,0,0,0,0,0,2'd3)); // 21 MEM_WAIT ignores redirect
        add(z,                                  mo(0,0,0,0,0,0,2'd0)); // 22

        // Reset and check the reset state.
        drive(z, 1'b0);
        repeat (2) @(posedge clk);
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd0), "reset_out");
        chk16("reset_stall_cnt", stall_cnt, 16'd0);
        chk16("reset_flush_cnt", flush_cnt, 16'd0);

        foreach (tbl[i]) begin
            step(tbl[i].vin, 1'b1, tbl[i].vout, $sformatf("vec%0d", i));
            if (i == 8) begin
                chk16("load_use_stall_cnt", stall_cnt, 16'd1);
            end
        end
        chk16("tbl_stall_cnt", stall_cnt, 16'd3);
        chk16("tbl_flush_cnt", flush_cnt, 16'd1);

        // Redirect followed by mem_busy while in FLUSH.
        v = z; v.redir = 1'b1;
        step(v, 1'b1, mo(0,0,1,1,0,0,2'd0), "fb_redirect");
        v = z; v.busy = 1'b1;
        step(v, 1'b1, mo(0,0,1,0,0,0,2'd2), "fb_flush_busy");
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd3), "fb_memwait_exit");
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd0), "fb_run");
        chk16("fb_flush_cnt", flush_cnt, 16'd2);
        chk16("fb_stall_cnt", stall_cnt, 16'd3);

        // Reset asserted while in MEM_WAIT.
        v = z; v.busy = 1'b1;
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd0), "rm_enter");
        step(v, 1'b0, mo(1,1,0,0,0,0,2'd3), "rm_rst_busy");
        step(z, 1'b0, mo(0,0,0,0,0,0,2'd0), "rm_rst_idle");
        chk16("rm_stall_cnt", stall_cnt, 16'd0);
        chk16("rm_flush_cnt", flush_cnt, 16'd0);
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd0), "rm_release");

        // mem_busy for three cycles with a redirect pulse inside MEM_WAIT.
        v = z; v.busy = 1'b1;
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd0), "mw_c1");
        v.redir = 1'b1;
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd3), "mw_c2_redirect");
        v.redir = 1'b0;
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd3), "mw_c3");
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd3), "mw_c4_release");
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd0), "mw_run");
        chk16("mw_stall_cnt", stall_cnt, 16'd3);
        chk16("mw_flush_cnt", flush_cnt, 16'd0);

        // Long memory hold drives stall_cnt to saturation.
        v = z; v.busy = 1'b1;
        @(posedge clk);
        #1;
        drive(v, 1'b1);
        repeat (65536) @(posedge clk);
        @(negedge clk);
        chk16("sat_stall_cnt", stall_cnt, 16'hFFFF);
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd3), "sat_hold");
        step(v, 1'b1, mo(1,1,0,0,0,0,2'd3), "sat_hold2");
        chk16("sat_stall_cnt_held", stall_cnt, 16'hFFFF);
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd3), "sat_release");
        step(z, 1'b1, mo(0,0,0,0,0,0,2'd0), "sat_run");
        chk16("sat_stall_cnt_final", stall_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL have ports: id_rs1_addr, id_rs2_addr  in  5 each  source register indices of the ID instruction.
REQ-005 SHALL have ports: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-006 SHALL have port: ex_valid  in  1  EX stage holds a real (non-skipped) instruction.
REQ-007 SHALL have port: ex_rd_addr  in  5  destination of the EX instruction.
REQ-008 SHALL have ports: ex_wb_en, ex_wb_from_mem  in  1 each  EX instruction writes back; the writeback value comes from memory (load).
REQ-009 SHALL have port: ex_redirect  in  1  EX resolved a taken jump or branch this cycle.
REQ-010 SHALL have port: mem_busy  in  1  data memory not ready; whole pipe must hold.
REQ-011 SHALL have port: stall_front  out  1  hold PC and IF/ID contents.
REQ-012 SHALL have port: stall_id_ex  out  1  drives ID/EX hold (skip) input.
REQ-013 SHALL have port: bubble_id  out  1  drives ID/EX skip_instr input; the instruction entering EX is suppressed.
REQ-014 SHALL have port: flush_if_id  out  1  invalidate IF/ID contents.
REQ-015 SHALL have ports: rs1_take_prev1, rs2_take_prev1  out  1 each  forward the EX result to the ID instruction's operand.
REQ-016 SHALL have port: state  out  2  FSM state: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-017 SHALL have ports: stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-018 SHALL define load_use = ex_valid & ex_wb_en & ex_wb_from_mem & (ex_rd_addr!=0) & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-019 SHALL, in RUN, evaluate events in the priority order mem_busy > ex_redirect > load_use, acting only on the highest active one.
REQ-020 SHALL, in RUN with mem_busy=1, assert stall_front=1 and stall_id_ex=1 in the same cycle and go to MEM_WAIT.
REQ-021 SHALL, in MEM_WAIT, keep stall_front=1 and stall_id_ex=1 while mem_busy=1, ignore ex_redirect and load_use, and return to RUN on the first cycle mem_busy=0 with no stall asserted in that cycle.
REQ-022 SHALL, in RUN with ex_redirect=1 (mem_busy=0), assert flush_if_id=1 and bubble_id=1 in the same cycle and go to FLUSH.
REQ-023 SHALL, in FLUSH, assert bubble_id=1 for exactly one cycle, ignore ex_redirect and load_use, and go to RUN; mem_busy=1 in FLUSH SHALL go to MEM_WAIT instead, with bubble_id=1 still asserted in that cycle.
REQ-024 SHALL, in RUN with load_use=1 (no higher event), assert stall_front=1 and bubble_id=1 in the same cycle, and go to LOAD_STALL.
REQ-025 SHALL, in LOAD_STALL, assert no stall or bubble, force both take_prev1 outputs to 0, and go to RUN (MEM_WAIT if mem_busy=1).
REQ-026 SHALL, in RUN only, drive rsN_take_prev1 = ex_valid & ex_wb_en & !ex_wb_from_mem & (ex_rd_addr!=0) & id_uses_rsN & (id_rsN_addr==ex_rd_addr).
REQ-027 SHALL force both take_prev1 outputs to 0 in any cycle where stall_front or bubble_id is 1.
REQ-028 SHALL keep all control outputs combinational from state and inputs; state and counters SHALL be registered.
REQ-029 SHALL increment stall_cnt on every cycle with stall_front=1, saturating at 16'hFFFF.
REQ-030 SHALL increment flush_cnt on every RUN->FLUSH transition, saturating at 16'hFFFF.
REQ-031 SHALL treat register index 0 as never hazarding or forwarding.

Reset
REQ-032 SHALL, on any rising clk edge with rst=0, set state=RUN, stall_cnt=0, flush_cnt=0, overriding all events including mid-MEM_WAIT or FLUSH.
REQ-033 SHALL hold all control outputs at 0 while state=RUN and all inputs are 0; while rst=0, the control outputs SHALL follow the RUN decode.

Verification
REQ-034 SHALL cover: load x5 in EX, ID add reads x5 -> cycle N stall_front=1, bubble_id=1, state=1 at N+1, outputs all 0 at N+1, stall_cnt=1.
REQ-035 SHALL cover: ALU write x7 in EX, ID reads rs2=x7 -> rs2_take_prev1=1, rs1_take_prev1=0, no stall; same with rd=x0 -> both 0.
REQ-036 SHALL cover: ex_redirect=1 together with load_use=1 -> flush_if_id=1, bubble_id=1, no stall_front; FLUSH for one cycle, then RUN; flush_cnt=1.
REQ-037 SHALL cover: mem_busy high for 3 cycles -> stall_front=stall_id_ex=1 for 3 cycles, stall_cnt=3, RUN on the 4th cycle; redirect pulse during MEM_WAIT ignored.
REQ-038 SHALL cover: rst=0 asserted in MEM_WAIT -> state=RUN, counters=0 next cycle; stall_cnt preloaded near 16'hFFFF plus stall cycles -> holds at 16'hFFFF.
